regfile_write_queue: RTL
========================

Name: regfile_write_queue

Overview:
- Writer-side front end of the MIPS register file. It buffers writeback requests from the datapath's result producers (ALU, load, mult/div), which may arrive in bursts.
- Drains at most one request per cycle onto the register file write port (write_reg, write_data, RegWrite).
- Provides a combinational forwarding lookup so readers can see pending, not-yet-committed values.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 registers).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  writeback request present.
- req_ready  output  1  queue can accept; equals !full.
- req_reg  input  ADDR_W  destination register index.
- req_data  input  DATA_W  value to write.
- write_reg  output  ADDR_W  register file write index; registered.
- write_data  output  DATA_W  register file write data; registered.
- RegWrite  output  1  register file write enable; registered, one-cycle pulse per committed entry.
- lookup_reg  input  ADDR_W  forwarding query index.
- lookup_hit  output  1  a pending or in-flight write targets lookup_reg.
- lookup_data  output  DATA_W  newest pending value for lookup_reg; 0 when no hit.
- pending_count  output  $clog2(DEPTH+1)  number of queued entries; excludes the output register.
- empty  output  1  pending_count == 0.
- full  output  1  pending_count == DEPTH.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - Read/write pointers and pending_count = 0.
  - RegWrite = 0, write_reg = 0, write_data = 0.
  - Hence empty = 1, full = 0, req_ready = 1, lookup_hit = 0, lookup_data = 0.
- Reset mid-operation: all queued entries and any in-flight write are discarded. RegWrite is 0 in the cycle after the reset edge.
- Accept: an edge with req_valid && req_ready is a handshake.
  - req_reg != 0: entry {req_reg, req_data} written at the tail; tail pointer advances.
  - req_reg == 0: handshake completes but nothing is enqueued ($zero is protected).
- req_ready is purely !full. It does not anticipate a same-cycle pop.
- Drain, at each edge:
  - If !empty: the head is popped into write_reg/write_data and RegWrite = 1 for the following cycle.
  - Else: RegWrite = 0; write_reg/write_data hold their last values.
- Latency: a request accepted at edge N into an empty queue drives RegWrite high during the cycle after edge N+1.
- Throughput: one commit per cycle sustained.
- Simultaneous push and pop: both occur; pending_count is unchanged.
- Push into a full queue is impossible because req_ready = 0. Push into an empty queue with a same-edge pop: the pop sees the old empty state, so nothing is popped that edge.
- Ordering: strict FIFO. Multiple entries to the same register are all kept and committed in arrival order (WAW-safe).
- Pointers: ADDR width $clog2(DEPTH) and wrap modulo DEPTH. full/empty come from the count register, not from pointer comparison.
- Lookup (combinational) candidates are all valid queue entries plus the output register when RegWrite = 1.
  - Priority: youngest queue entry > older queue entries > output register.
  - lookup_reg == 0: hit 0, data 0.
  - No match: hit 0, data 0.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32, REG_ZERO = 5'd0.
  - Typedef wb_entry_t = struct {reg index, data}.
- Natural sub-module wb_fifo: storage array, head/tail pointers and count, with push/pop/full/empty and a flat view of entries with valid bits.
- Kept in the top level: the $zero filter, the output register, and the priority lookup.

Test Plan:
1. Reset, then idle → RegWrite = 0, write_reg = 0, write_data = 0, empty = 1, req_ready = 1, lookup_hit = 0.
2. Single push (reg 8, data 0xDEADBEEF) at edge N → RegWrite = 1, write_reg = 8, write_data = 0xDEADBEEF during the cycle after edge N+1; empty again afterwards.
3. Five back-to-back pushes (regs 1..5, data 0x11..0x55), DEPTH 4, drain running → req_ready drops only if full. All five are committed in order, one per cycle, with no loss or duplication.
4. Push (reg 0, 0x1234) → accepted; pending_count stays 0, RegWrite never asserts, and lookup on reg 0 gives hit 0, data 0.
5. Push reg 9 = 0xA, then reg 9 = 0xB; lookup_reg = 9 while both are pending → hit 1, data 0xB. Commits occur in order 0xA then 0xB.
6. Fill the queue with 4 entries, then assert reset for one edge → next cycle pending_count = 0, RegWrite = 0, lookup_hit = 0, and no stale entry is ever committed.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and constants.
// Used by the writeback queue and its FIFO storage.
package mips_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] idx;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Writeback entry FIFO: storage, head/tail pointers and occupancy count.
// Exposes every slot in age order (index 0 = oldest) with valid bits.
module wb_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  wb_entry_t        push_ent_i,
   input  logic             pop_i,
   output wb_entry_t        pop_ent_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o,
   output wb_entry_t        ent_o [DEPTH],
   output logic [DEPTH-1:0] vld_o
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign pop_ent_o = mem_q[head_q];

   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      head_d  = do_pop  ? head_q + 1'b1 : head_q;
      tail_d  = do_push ? tail_q + 1'b1 : tail_q;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[tail_q] <= push_ent_i;
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         ent_o[k] = mem_q[head_q + PTR_W'(k)];
         vld_o[k] = (CNT_W'(k) < count_q);
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// Register-file writeback queue: $zero filter, registered write port
// and a youngest-first forwarding lookup over pending writes.
module regfile_write_queue
   import mips_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = REG_DATA_W,
   parameter  int ADDR_W = REG_ADDR_W,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_reg,
   input  logic [DATA_W-1:0] req_data,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic              RegWrite,
   input  logic [ADDR_W-1:0] lookup_reg,
   output logic              lookup_hit,
   output logic [DATA_W-1:0] lookup_data,
   output logic [CNT_W-1:0]  pending_count,
   output logic              empty,
   output logic              full
);

   wb_entry_t        push_ent;
   wb_entry_t        head_ent;
   wb_entry_t        ent [DEPTH];
   logic [DEPTH-1:0] vld;
   logic             push;

   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;

   assign req_ready = !full;
   assign push      = req_valid && req_ready && (req_reg != REG_ZERO);

   always_comb begin
      push_ent.idx  = req_reg;
      push_ent.data = req_data;
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .push_ent_i (push_ent),
      .pop_i      (!empty),
      .pop_ent_o  (head_ent),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (pending_count),
      .ent_o      (ent),
      .vld_o      (vld)
   );

   always_comb begin
      we_d    = !empty;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      if (!empty) begin
         wreg_d  = head_ent.idx;
         wdata_d = head_ent.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
      end
   end

   assign RegWrite   = we_q;
   assign write_reg  = wreg_q;
   assign write_data = wdata_q;

   // Scan oldest to youngest so the newest match wins.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      if (lookup_reg != REG_ZERO) begin
         if (we_q && (wreg_q == lookup_reg)) begin
            lookup_hit  = 1'b1;
            lookup_data = wdata_q;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && (ent[k].idx == lookup_reg)) begin
               lookup_hit  = 1'b1;
               lookup_data = ent[k].data;
            end
         end
      end
   end

endmodule
